ram_arbiter: RTL

Two-port round-robin arbiter and access sequencer for the 32 x 8 single-port RAM block. It accepts read/write transactions from two requesters, serialises them onto the RAM's single port, and returns read data with a one-cycle acknowledge pulse. It is the only driver of the RAM's `wena`/`addr`/`data_in` pins.

---
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester, status and RAM-port signals of the two-port RAM arbiter.
// The arbiter takes the slave view; the requesters and RAM model take the master view.
interface ram_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          busy;
  logic          ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output ack0, ack1, rdata0, rdata1, busy, ram_wena, ram_addr, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  ack0, ack1, rdata0, rdata1, busy, ram_wena, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two requesters onto a single-port 32x8 RAM.
// Each transaction walks IDLE -> SETUP -> ACCESS -> ACK; all outputs are registered.
module ram_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic        clk,
  input  logic        rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StAck} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          ram_wena_q, ram_wena_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic grant_valid;
  logic grant_id;

  // On a tie the requester that did not win the previous grant goes next.
  always_comb begin
    grant_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = bus.req1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_valid) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next values, keyed on the state being entered
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wena_d   = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    busy_d       = (state_d != StIdle);

    if (state_q == StIdle && grant_valid) begin
      last_grant_d = grant_id;
      owner_d      = grant_id;
      lat_we_d     = grant_id ? bus.we1    : bus.we0;
      lat_addr_d   = grant_id ? bus.addr1  : bus.addr0;
      lat_wdata_d  = grant_id ? bus.wdata1 : bus.wdata0;
    end

    if (state_q == StAccess && !lat_we_q) begin
      if (owner_q) begin
        rdata1_d = bus.ram_rdata;
      end else begin
        rdata0_d = bus.ram_rdata;
      end
    end

    unique case (state_d)
      // Inverted address guarantees the RAM sees an address change entering ACCESS.
      StSetup: ram_addr_d = ~lat_addr_d;
      StAccess: begin
        ram_addr_d  = lat_addr_q;
        ram_wena_d  = lat_we_q;
        ram_wdata_d = lat_wdata_q;
      end
      StAck: begin
        ack0_d = ~owner_q;
        ack1_d = owner_q;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
      ram_wena_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      ram_wena_q   <= ram_wena_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = busy_q;
  assign bus.ram_wena  = ram_wena_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule
